// File: rtl/instr_pkg.sv
// Shared definitions for the instruction issue controller.
// Instruction format is {op[7:4], dst[3:2], src[1:0]}. The field slice constants,
// the default NOP/HALT opcodes, the issue FSM state type and a packed view of
// the held instruction are defined here.
package instr_pkg;

    localparam int OP_MSB  = 7;
    localparam int OP_LSB  = 4;
    localparam int DST_MSB = 3;
    localparam int DST_LSB = 2;
    localparam int SRC_MSB = 1;
    localparam int SRC_LSB = 0;

    localparam logic [3:0] NOP_OP_DEF  = 4'h0;
    localparam logic [3:0] HALT_OP_DEF = 4'hF;

    // Encoding is exposed on dbg_state, so keep the values fixed.
    typedef enum logic [1:0] {
        EMPTY  = 2'd0,
        LOADED = 2'd1,
        HALTED = 2'd2
    } issue_state_t;

    typedef struct packed {
        logic [3:0] op;
        logic [1:0] dst;
        logic [1:0] src;
    } instr_t;

    function automatic instr_t unpack_instr(input logic [7:0] raw);
        instr_t r;
        r.op  = raw[OP_MSB:OP_LSB];
        r.dst = raw[DST_MSB:DST_LSB];
        r.src = raw[SRC_MSB:SRC_LSB];
        return r;
    endfunction

endpackage

// File: rtl/reg_scoreboard.sv
// Pending-write scoreboard for the four architectural registers.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   set_en, set_idx   mark a register busy (issue of a writing instruction)
//   clr_en, clr_idx   writeback completes for a register
//   busy              one bit per register, registered
//   wb_err            sticky: a writeback arrived for a register that was not busy
module reg_scoreboard (
    input  logic       clk,
    input  logic       rst,
    input  logic       set_en,
    input  logic [1:0] set_idx,
    input  logic       clr_en,
    input  logic [1:0] clr_idx,
    output logic [3:0] busy,
    output logic       wb_err
);

    logic [3:0] busy_q, busy_d;
    logic       wb_err_q, wb_err_d;

    always_comb begin
        busy_d   = busy_q;
        wb_err_d = wb_err_q;
        // Clear is applied first so that a set on the same register wins.
        if (clr_en) begin
            if (!busy_q[clr_idx]) begin
                wb_err_d = 1'b1;
            end
            busy_d[clr_idx] = 1'b0;
        end
        if (set_en) begin
            busy_d[set_idx] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q   <= 4'b0000;
            wb_err_q <= 1'b0;
        end else begin
            busy_q   <= busy_d;
            wb_err_q <= wb_err_d;
        end
    end

    assign busy   = busy_q;
    assign wb_err = wb_err_q;

endmodule

// File: rtl/instr_issue_ctrl.sv
// In-order issue controller in front of the decode stage. Holds one fetched
// instruction, blocks it on RAW/WAW hazards against the scoreboard, and handles
// NOP (issued, not tracked) and HALT (waits for all writes to drain, then stops
// until resume).
// Handshake: a transfer happens on a cycle where valid && ready are both high
// at the rising edge; valid never depends on ready from the same interface,
// while instr_ready may depend combinationally on iss_ready to allow
// back-to-back issue.
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   instr_valid/ready/data      fetch side, data = {op, dst, src}
//   iss_valid/ready/op/dst/src  issue side, fields are registered
//   wb_valid, wb_reg            writeback completion
//   resume                      leave HALTED
//   halted, busy, stall_cnt     status
//   wb_err                      sticky spurious-writeback flag
//   dbg_state                   current FSM state
module instr_issue_ctrl
    import instr_pkg::*;
#(
    parameter int         STALL_W = 8,
    parameter logic [3:0] NOP_OP  = NOP_OP_DEF,
    parameter logic [3:0] HALT_OP = HALT_OP_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               instr_valid,
    input  logic [7:0]         instr_data,
    output logic               instr_ready,
    output logic               iss_valid,
    input  logic               iss_ready,
    output logic [3:0]         iss_op,
    output logic [1:0]         iss_dst,
    output logic [1:0]         iss_src,
    input  logic               wb_valid,
    input  logic [1:0]         wb_reg,
    input  logic               resume,
    output logic               halted,
    output logic [3:0]         busy,
    output logic [STALL_W-1:0] stall_cnt,
    output logic               wb_err,
    output issue_state_t       dbg_state
);

    issue_state_t       state_q, state_d;
    instr_t             instr_q, instr_d;
    logic [STALL_W-1:0] stall_q, stall_d;

    logic       set_en;
    logic       hazard;
    logic       fire;
    logic [3:0] busy_w;

    reg_scoreboard u_sb (
        .clk     (clk),
        .rst     (rst),
        .set_en  (set_en),
        .set_idx (instr_q.dst),
        .clr_en  (wb_valid),
        .clr_idx (wb_reg),
        .busy    (busy_w),
        .wb_err  (wb_err)
    );

    // Registered busy only: a writeback clearing at edge N unblocks at N+1.
    assign hazard = (instr_q.op != NOP_OP) &&
                    (busy_w[instr_q.src] || busy_w[instr_q.dst]);

    always_comb begin
        state_d     = state_q;
        instr_d     = instr_q;
        stall_d     = '0;
        instr_ready = 1'b0;
        iss_valid   = 1'b0;
        halted      = 1'b0;
        set_en      = 1'b0;
        fire        = 1'b0;
        unique case (state_q)
            EMPTY: begin
                instr_ready = 1'b1;
                if (instr_valid) begin
                    instr_d = unpack_instr(instr_data);
                    state_d = LOADED;
                end
            end
            LOADED: begin
                if (instr_q.op != HALT_OP) begin
                    iss_valid   = !hazard;
                    fire        = iss_valid && iss_ready;
                    instr_ready = fire;
                    if (fire) begin
                        set_en = (instr_q.op != NOP_OP);
                        if (instr_valid) begin
                            instr_d = unpack_instr(instr_data);
                        end else begin
                            state_d = EMPTY;
                        end
                    end else if (stall_q != {STALL_W{1'b1}}) begin
                        stall_d = stall_q + STALL_W'(1);
                    end else begin
                        stall_d = stall_q;
                    end
                end else if (busy_w == 4'b0000) begin
                    // HALT is consumed here and never reaches decode.
                    state_d = HALTED;
                end
            end
            HALTED: begin
                halted = 1'b1;
                if (resume) begin
                    state_d = EMPTY;
                end
            end
            default: begin
                state_d = EMPTY;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= EMPTY;
            instr_q <= '0;
            stall_q <= '0;
        end else begin
            state_q <= state_d;
            instr_q <= instr_d;
            stall_q <= stall_d;
        end
    end

    assign iss_op    = instr_q.op;
    assign iss_dst   = instr_q.dst;
    assign iss_src   = instr_q.src;
    assign busy      = busy_w;
    assign stall_cnt = stall_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_instr_issue_ctrl.sv
// Directed bench for instr_issue_ctrl. Inputs change 1 ns after each rising
// edge; outputs are checked 1 ns later, well clear of the next edge.
module tb_instr_issue_ctrl;
    import instr_pkg::*;

    logic         clk = 1'b0;
    logic         rst;
    logic         instr_valid;
    logic [7:0]   instr_data;
    logic         instr_ready;
    logic         iss_valid;
    logic         iss_ready;
    logic [3:0]   iss_op;
    logic [1:0]   iss_dst;
    logic [1:0]   iss_src;
    logic         wb_valid;
    logic [1:0]   wb_reg;
    logic         resume;
    logic         halted;
    logic [3:0]   busy;
    logic [7:0]   stall_cnt;
    logic         wb_err;
    issue_state_t dbg_state;

    int n_checks = 0;
    int n_fail   = 0;

    instr_issue_ctrl #(.STALL_W(8)) dut (
        .clk         (clk),
        .rst         (rst),
        .instr_valid (instr_valid),
        .instr_data  (instr_data),
        .instr_ready (instr_ready),
        .iss_valid   (iss_valid),
        .iss_ready   (iss_ready),
        .iss_op      (iss_op),
        .iss_dst     (iss_dst),
        .iss_src     (iss_src),
        .wb_valid    (wb_valid),
        .wb_reg      (wb_reg),
        .resume      (resume),
        .halted      (halted),
        .busy        (busy),
        .stall_cnt   (stall_cnt),
        .wb_err      (wb_err),
        .dbg_state   (dbg_state)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1; instr_valid = 1'b0; instr_data = 8'h00; iss_ready = 1'b0;
        wb_valid = 1'b0; wb_reg = 2'd0; resume = 1'b0;
        tick(); tick();
        rst = 1'b0;
        tick(); #1;
        // Reset state
        chk("rst_state", 32'(dbg_state), 32'(EMPTY));
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_stall", 32'(stall_cnt), 32'h0);
        chk("rst_wb_err", 32'(wb_err), 32'h0);
        chk("rst_iss_valid", 32'(iss_valid), 32'h0);
        chk("rst_instr_ready", 32'(instr_ready), 32'h1);
        chk("rst_halted", 32'(halted), 32'h0);
        chk("rst_iss_op", 32'(iss_op), 32'h0);

        // resume outside HALTED does nothing
        resume = 1'b1; tick(); resume = 1'b0; #1;
        chk("resume_ign", 32'(dbg_state), 32'(EMPTY));

        // Basic: 8'h16 = op1 dst1 src2, 8'h2B = op2 dst2 src3
        instr_valid = 1'b1; instr_data = 8'h16; iss_ready = 1'b1;
        tick();
        instr_data = 8'h2B; #1;
        chk("b1_valid", 32'(iss_valid), 32'h1);
        chk("b1_fields", {26'd0, iss_op, iss_dst}, {26'd0, 4'h1, 2'd1});
        chk("b1_src", 32'(iss_src), 32'h2);
        chk("b1_ready", 32'(instr_ready), 32'h1);
        tick();
        instr_valid = 1'b0; #1;
        chk("b2_valid", 32'(iss_valid), 32'h1);
        chk("b2_fields", {24'd0, iss_op, iss_dst, iss_src}, {24'd0, 4'h2, 2'd2, 2'd3});
        chk("b2_busy", 32'(busy), 32'b0010);
        tick(); #1;
        // dst1 and dst2 pending -> bits 1 and 2
        chk("b_busy_both", 32'(busy), 32'b0110);
        chk("b_empty", 32'(dbg_state), 32'(EMPTY));
        chk("b_iss_valid0", 32'(iss_valid), 32'h0);
        wb_valid = 1'b1; wb_reg = 2'd1; tick();
        wb_reg = 2'd2; tick();
        wb_valid = 1'b0; #1;
        chk("b_drained", 32'(busy), 32'h0);
        chk("b_no_err", 32'(wb_err), 32'h0);

        // RAW: 8'h14 = op1 dst1 src0, then 8'h31 = op3 dst0 src1
        instr_valid = 1'b1; instr_data = 8'h14; tick();
        instr_data = 8'h31; #1;
        chk("raw_first", 32'(iss_valid), 32'h1);
        tick();
        instr_valid = 1'b0; #1;
        chk("raw_blocked", 32'(iss_valid), 32'h0);
        chk("raw_nready", 32'(instr_ready), 32'h0);
        chk("raw_op", 32'(iss_op), 32'h3);
        chk("raw_stall0", 32'(stall_cnt), 32'h0);
        tick(); tick(); tick(); #1;
        chk("raw_stall3", 32'(stall_cnt), 32'h3);
        chk("raw_still", 32'(iss_valid), 32'h0);
        wb_valid = 1'b1; wb_reg = 2'd1; tick();
        wb_valid = 1'b0; #1;
        chk("raw_unblock", 32'(iss_valid), 32'h1);
        chk("raw_busy0", 32'(busy), 32'h0);
        chk("raw_stall4", 32'(stall_cnt), 32'h4);
        tick(); #1;
        chk("raw_fired_stall", 32'(stall_cnt), 32'h0);
        chk("raw_fired_busy", 32'(busy), 32'b0001);
        chk("raw_empty", 32'(dbg_state), 32'(EMPTY));
        wb_valid = 1'b1; wb_reg = 2'd0; tick(); wb_valid = 1'b0;

        // Backpressure: 8'h2B held with iss_ready=0, next instr offered
        iss_ready = 1'b0; instr_valid = 1'b1; instr_data = 8'h2B; tick();
        instr_data = 8'h3C; #1;
        chk("bp_valid0", 32'(iss_valid), 32'h1);
        chk("bp_nready0", 32'(instr_ready), 32'h0);
        for (int i = 0; i < 5; i++) begin
            tick(); #1;
            chk("bp_valid", 32'(iss_valid), 32'h1);
            chk("bp_nready", 32'(instr_ready), 32'h0);
        end
        chk("bp_stall5", 32'(stall_cnt), 32'h5);
        chk("bp_hold", {24'd0, iss_op, iss_dst, iss_src}, {24'd0, 4'h2, 2'd2, 2'd3});
        iss_ready = 1'b1; instr_valid = 1'b0; #1;
        chk("bp_release_rdy", 32'(instr_ready), 32'h1);
        tick(); #1;
        chk("bp_one_fire", 32'(busy), 32'b0100);
        chk("bp_empty", 32'(iss_valid), 32'h0);
        chk("bp_stall_clr", 32'(stall_cnt), 32'h0);
        tick(); #1;
        chk("bp_no_refire", 32'(busy), 32'b0100);
        wb_valid = 1'b1; wb_reg = 2'd2; tick(); wb_valid = 1'b0;

        // NOP 8'h05 (dst1 src1) while busy[1]=1
        instr_valid = 1'b1; instr_data = 8'h14; tick();
        instr_data = 8'h05; tick();
        instr_valid = 1'b0; #1;
        chk("nop_busy1", 32'(busy), 32'b0010);
        chk("nop_valid", 32'(iss_valid), 32'h1);
        chk("nop_op", 32'(iss_op), 32'h0);
        tick(); #1;
        chk("nop_untracked", 32'(busy), 32'b0010);
        chk("nop_empty", 32'(dbg_state), 32'(EMPTY));
        wb_valid = 1'b1; wb_reg = 2'd1; tick(); wb_valid = 1'b0;

        // HALT: 8'h1C = op1 dst3 src0, then 8'hF0
        instr_valid = 1'b1; instr_data = 8'h1C; tick();
        instr_data = 8'hF0; tick();
        instr_valid = 1'b0; #1;
        chk("halt_busy3", 32'(busy), 32'b1000);
        chk("halt_no_iss", 32'(iss_valid), 32'h0);
        chk("halt_nready", 32'(instr_ready), 32'h0);
        chk("halt_wait", 32'(halted), 32'h0);
        tick(); #1;
        chk("halt_wait2", 32'(halted), 32'h0);
        chk("halt_loaded", 32'(dbg_state), 32'(LOADED));
        wb_valid = 1'b1; wb_reg = 2'd3; tick();
        wb_valid = 1'b0; #1;
        chk("halt_drained", 32'(halted), 32'h0);
        tick(); #1;
        chk("halt_on", 32'(halted), 32'h1);
        chk("halt_nready2", 32'(instr_ready), 32'h0);
        chk("halt_noiss2", 32'(iss_valid), 32'h0);
        instr_valid = 1'b1; instr_data = 8'h16; tick(); #1;
        chk("halt_holds", 32'(dbg_state), 32'(HALTED));
        instr_valid = 1'b0; resume = 1'b1; tick();
        resume = 1'b0; #1;
        chk("resume_empty", 32'(dbg_state), 32'(EMPTY));
        chk("resume_ready", 32'(instr_ready), 32'h1);
        chk("resume_halted0", 32'(halted), 32'h0);
        chk("resume_busy", 32'(busy), 32'h0);

        // Spurious writeback to reg2 with nothing pending
        wb_valid = 1'b1; wb_reg = 2'd2; tick();
        wb_valid = 1'b0; #1;
        chk("err_set", 32'(wb_err), 32'h1);
        chk("err_busy", 32'(busy), 32'h0);
        tick(); #1;
        chk("err_sticky", 32'(wb_err), 32'h1);

        // Reset while LOADED with a pending write
        instr_valid = 1'b1; instr_data = 8'h16; iss_ready = 1'b1; tick();
        instr_data = 8'h2B; tick();
        instr_valid = 1'b0; iss_ready = 1'b0; #1;
        chk("pre_rst_busy", 32'(busy), 32'b0010);
        chk("pre_rst_valid", 32'(iss_valid), 32'h1);
        rst = 1'b1; tick();
        rst = 1'b0; #1;
        chk("mid_rst_busy", 32'(busy), 32'h0);
        chk("mid_rst_valid", 32'(iss_valid), 32'h0);
        chk("mid_rst_err", 32'(wb_err), 32'h0);
        chk("mid_rst_instr", {24'd0, iss_op, iss_dst, iss_src}, 32'h0);
        chk("mid_rst_ready", 32'(instr_ready), 32'h1);

        // Stall counter saturation
        instr_valid = 1'b1; instr_data = 8'h2B; tick();
        instr_valid = 1'b0;
        for (int i = 0; i < 260; i++) tick();
        #1;
        chk("stall_sat", 32'(stall_cnt), 32'hFF);
        iss_ready = 1'b1; tick(); #1;
        chk("stall_sat_clr", 32'(stall_cnt), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
